// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port data memory between two masters: port 0 (the
//   processor) and port 1 (the debug/loader engine). Arbitration is
//   round-robin with a bounded burst. Each read word is steered back to the
//   master that issued the read.
//
//   Ports
//     clock, reset            rising-edge clock, asynchronous active-low reset
//     req*/we*/addr*/wdata*   per-master request; held stable until granted
//     gnt*                    1-cycle pulse in the cycle the access reaches dmem
//     rvalid*/rdata*          read return, one cycle after a read grant
//                             (rdata is 0 whenever rvalid is low)
//     address_dmem/data/wren  dmem request pins; address/data hold their
//                             last driven value in cycles with no grant
//     q_dmem                  dmem read data, valid one cycle after a read
module dmem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);
    localparam logic [3:0] CNT_ONE = 4'd1;

    state_t            state_r, state_nxt_s;
    logic              last_r, last_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic              grant_s;
    logic              win_s;
    logic              own_s;
    logic              own_req_s;
    logic              oth_req_s;
    logic              gnt_en_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] data_hold_r;
    logic              rd_valid_r;
    logic              rd_tag_r;

    // Arbitration: next owner, burst counter and round-robin pointer.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        grant_s     = 1'b0;
        win_s       = 1'b0;
        own_s       = (state_r == ST_OWN1);
        own_req_s   = own_s ? req1 : req0;
        oth_req_s   = own_s ? req0 : req1;
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    grant_s = 1'b1;
                    win_s   = ~last_r;
                end else if (req0) begin
                    grant_s = 1'b1;
                    win_s   = 1'b0;
                end else if (req1) begin
                    grant_s = 1'b1;
                    win_s   = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                if (grant_s) begin
                    state_nxt_s = win_s ? ST_OWN1 : ST_OWN0;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (own_req_s) begin
                    if (!oth_req_s) begin
                        // Uncontested: keep the port, counter saturates.
                        grant_s   = 1'b1;
                        win_s     = own_s;
                        cnt_nxt_s = (cnt_r < MAX_CNT) ? (cnt_r + CNT_ONE) : cnt_r;
                    end else if (cnt_r < MAX_CNT) begin
                        grant_s   = 1'b1;
                        win_s     = own_s;
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        // Burst exhausted with the other port waiting: hand over.
                        grant_s     = 1'b1;
                        win_s       = ~own_s;
                        state_nxt_s = own_s ? ST_OWN0 : ST_OWN1;
                        last_nxt_s  = own_s;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else if (oth_req_s) begin
                    grant_s     = 1'b1;
                    win_s       = ~own_s;
                    state_nxt_s = own_s ? ST_OWN0 : ST_OWN1;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // No grant can reach the pins while reset is held, even with requests up.
    assign gnt_en_s   = grant_s & reset;
    assign win_addr_s = win_s ? addr1  : addr0;
    assign win_data_s = win_s ? wdata1 : wdata0;
    assign win_we_s   = win_s ? we1    : we0;

    assign gnt0         = gnt_en_s & ~win_s;
    assign gnt1         = gnt_en_s & win_s;
    assign wren         = gnt_en_s & win_we_s;
    assign address_dmem = gnt_en_s ? win_addr_s : addr_hold_r;
    assign data         = gnt_en_s ? win_data_s : data_hold_r;

    assign rvalid0 = rd_valid_r & ~rd_tag_r;
    assign rvalid1 = rd_valid_r & rd_tag_r;
    assign rdata0  = rvalid0 ? q_dmem : {DATA_W{1'b0}};
    assign rdata1  = rvalid1 ? q_dmem : {DATA_W{1'b0}};

    // Arbiter state, held dmem pin values and the one-deep read tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            cnt_r       <= 4'd0;
            addr_hold_r <= {ADDR_W{1'b0}};
            data_hold_r <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            rd_tag_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            cnt_r      <= cnt_nxt_s;
            // Retagged every cycle, so a write right after a read cannot
            // clobber the pending return: the tag is consumed the same cycle.
            rd_valid_r <= gnt_en_s & ~win_we_s;
            rd_tag_r   <= win_s;
            if (gnt_en_s) begin
                addr_hold_r <= win_addr_s;
                data_hold_r <= win_data_s;
            end else begin
                addr_hold_r <= addr_hold_r;
                data_hold_r <= data_hold_r;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [11:0] addr0 = 12'd0, addr1 = 12'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        gnt0, gnt1, rvalid0, rvalid1, wren;
    logic [31:0] rdata0, rdata1, data;
    logic [11:0] address_dmem;
    logic [31:0] q_dmem = 32'd0;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    // Memory environment: unwritten word a reads as 32'hC0DE0000 | a.
    bit [31:0] mem [4096];
    bit        wr_mask [4096];
    always @(posedge clock) begin
        if (wren) begin
            mem[address_dmem]     <= data;
            wr_mask[address_dmem] <= 1'b1;
        end
        q_dmem <= wr_mask[address_dmem] ? mem[address_dmem]
                                        : (32'hC0DE0000 | {20'd0, address_dmem});
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [11:0] addr;
        logic        we;
        logic [31:0] wd;
        int          cyc;
    } gexp_t;
    typedef struct {
        int          port;
        logic [31:0] rd;
        int          cyc;
    } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    task automatic exp_gnt(input int p, input logic [11:0] a, input logic we, input logic [31:0] wd);
        gexp_t e;
        e.port = p; e.addr = a; e.we = we; e.wd = wd; e.cyc = cyc;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] d);
        rexp_t e;
        e.port = p; e.rd = d; e.cyc = cyc + 1;
        rq.push_back(e);
    endtask

    task automatic set0(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctl", 64'({gnt0, gnt1, rvalid0, rvalid1, wren}), 64'd0);
        chk("rst_addr", 64'(address_dmem), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_rdata", {rdata0, rdata1}, 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a read return.
    always @(negedge clock) begin
        gexp_t ge;
        rexp_t re;
        if (gnt0 || gnt1) begin
            chk("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
            chk("gnt_pending", 64'(gq.size() != 0), 64'd1);
            if (gq.size() != 0) begin
                ge = gq.pop_front();
                chk("gnt_port", 64'(gnt1), 64'(ge.port));
                chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                chk("gnt_addr", 64'(address_dmem), 64'(ge.addr));
                chk("gnt_wren", 64'(wren), 64'(ge.we));
                if (ge.we) chk("gnt_wdata", 64'(data), 64'(ge.wd));
            end
        end else begin
            chk("wren_idle", 64'(wren), 64'd0);
        end
        if (rvalid0 || rvalid1) begin
            chk("rv_onehot", 64'(rvalid0 & rvalid1), 64'd0);
            chk("rv_pending", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
                re = rq.pop_front();
                chk("rv_port", 64'(rvalid1), 64'(re.port));
                chk("rv_cycle", 64'(cyc), 64'(re.cyc));
                chk("rdata", 64'(rvalid1 ? rdata1 : rdata0), 64'(re.rd));
                chk("rdata_other", 64'(rvalid1 ? rdata0 : rdata1), 64'd0);
            end
        end else begin
            chk("rdata_idle", {rdata0, rdata1}, 64'd0);
        end
    end

    int seq2 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        // 1: reset held with a pending read request, then zero-latency grant.
        set0(1'b1, 1'b0, 12'h010, 32'd0);
        repeat (3) begin
            step();
            chk_reset_outputs();
        end
        reset = 1'b1;
        exp_gnt(0, 12'h010, 1'b0, 32'd0);
        exp_rd(0, 32'hC0DE0010);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        step();

        // 2: both ports saturated -> bursts of four.
        set0(1'b1, 1'b0, 12'h020, 32'd0);
        set1(1'b1, 1'b0, 12'h021, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (seq2[i] == 0) begin
                exp_gnt(0, 12'h020, 1'b0, 32'd0);
                exp_rd(0, 32'hC0DE0020);
            end else begin
                exp_gnt(1, 12'h021, 1'b0, 32'd0);
                exp_rd(1, 32'hC0DE0021);
            end
            step();
        end
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        set1(1'b0, 1'b0, 12'h000, 32'd0);
        step();

        // 3: port 1 writes, port 0 reads the same word back.
        set1(1'b1, 1'b1, 12'h0FF, 32'hDEADBEEF);
        exp_gnt(1, 12'h0FF, 1'b1, 32'hDEADBEEF);
        step();
        set1(1'b0, 1'b0, 12'h000, 32'd0);
        set0(1'b1, 1'b0, 12'h0FF, 32'd0);
        exp_gnt(0, 12'h0FF, 1'b0, 32'd0);
        exp_rd(0, 32'hDEADBEEF);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        step();

        // 4: interleaved reads from both ports on consecutive cycles.
        set0(1'b1, 1'b0, 12'h005, 32'd0);
        exp_gnt(0, 12'h005, 1'b0, 32'd0);
        exp_rd(0, 32'hC0DE0005);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        set1(1'b1, 1'b0, 12'h006, 32'd0);
        exp_gnt(1, 12'h006, 1'b0, 32'd0);
        exp_rd(1, 32'hC0DE0006);
        step();
        set1(1'b0, 1'b0, 12'h000, 32'd0);
        step();

        // 5: long uncontested run, then a late request is served at once.
        set0(1'b1, 1'b0, 12'h030, 32'd0);
        for (int i = 0; i < 10; i++) begin
            exp_gnt(0, 12'h030, 1'b0, 32'd0);
            exp_rd(0, 32'hC0DE0030);
            step();
        end
        set1(1'b1, 1'b0, 12'h031, 32'd0);
        exp_gnt(1, 12'h031, 1'b0, 32'd0);
        exp_rd(1, 32'hC0DE0031);
        step();
        set1(1'b0, 1'b0, 12'h000, 32'd0);
        exp_gnt(0, 12'h030, 1'b0, 32'd0);
        exp_rd(0, 32'hC0DE0030);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        step();

        // 6: reset right after a read grant discards the return.
        set0(1'b1, 1'b0, 12'h007, 32'd0);
        exp_gnt(0, 12'h007, 1'b0, 32'd0);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        reset = 1'b0;
        #2;
        chk_reset_outputs();
        step();
        chk_reset_outputs();
        reset = 1'b1;
        set0(1'b1, 1'b0, 12'h040, 32'd0);
        set1(1'b1, 1'b0, 12'h041, 32'd0);
        exp_gnt(0, 12'h040, 1'b0, 32'd0);
        exp_rd(0, 32'hC0DE0040);
        step();
        set0(1'b0, 1'b0, 12'h000, 32'd0);
        exp_gnt(1, 12'h041, 1'b0, 32'd0);
        exp_rd(1, 32'hC0DE0041);
        step();
        set1(1'b0, 1'b0, 12'h000, 32'd0);
        repeat (3) step();

        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rd_queue_drained", 64'(rq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
